muldiv_unit: RTL

//  EX-stage multi-cycle multiply/divide unit. Consumes the 6-bit ALU funct code produced in ID.

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_unit_div_iter.sv | 66 ++++++
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared ALU funct encodings and the operation decode used by the multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [2:0] {
    OpNone,
    OpMult,
    OpMultu,
    OpDiv,
    OpDivu,
    OpMthi,
    OpMtlo
  } md_op_e;

  function automatic md_op_e decode_op(input logic [5:0] funct);
    md_op_e op;
    case (funct)
      FUNCT_MULT:  op = OpMult;
      FUNCT_MULTU: op = OpMultu;
      FUNCT_DIV:   op = OpDiv;
      FUNCT_DIVU:  op = OpDivu;
      FUNCT_MTHI:  op = OpMthi;
      FUNCT_MTLO:  op = OpMtlo;
      default:     op = OpNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, DATA_WIDTH cycles per divide.
// done is asserted during the final iteration with quotient/remainder valid combinationally.
module muldiv_unit_div_iter
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  logic                  busy_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] div_q;

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;

  // quo_q starts as the dividend and shifts its bits into the partial remainder
  assign shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff     = shifted - {1'b0, div_q};
  assign rem_next = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
  assign quo_next = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};

  assign done      = busy_q && (cnt_q == CntLast);
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      div_q  <= divisor;
    end else if (busy_q) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + CntW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Stalls the pipeline while a MULT/DIV runs, then releases it for exactly one DONE cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  flush,
  output logic                  stall_req,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam int unsigned CntW      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int unsigned PipeDepth = (MUL_CYCLES > 1) ? MUL_CYCLES - 1 : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;
  logic                  signed_q;

  md_op_e op;
  logic   is_mul, is_div, accept;

  assign op     = decode_op(funct);
  assign is_mul = (op == OpMult) || (op == OpMultu);
  assign is_div = (op == OpDiv) || (op == OpDivu);
  assign accept = (state_q == StIdle) && valid_in && !flush;

  // Multiplier: sign- or zero-extend to 2W so a plain 2W-bit product is correct for both modes
  logic [2*DATA_WIDTH-1:0] mul_a_ext, mul_b_ext, product, mul_result;
  logic [2*DATA_WIDTH-1:0] pipe_q [PipeDepth];

  assign mul_a_ext = signed_q ? {{DATA_WIDTH{op_a_q[DATA_WIDTH-1]}}, op_a_q}
                              : {{DATA_WIDTH{1'b0}}, op_a_q};
  assign mul_b_ext = signed_q ? {{DATA_WIDTH{op_b_q[DATA_WIDTH-1]}}, op_b_q}
                              : {{DATA_WIDTH{1'b0}}, op_b_q};
  assign product   = mul_a_ext * mul_b_ext;

  always_ff @(posedge clk) begin
    pipe_q[0] <= product;
    for (int i = 1; i < int'(PipeDepth); i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  // HI/LO is the last stage of the chain, so the chain itself is one shorter than MUL_CYCLES
  assign mul_result = (MUL_CYCLES > 1) ? pipe_q[PipeDepth-1] : product;

  // Divider: magnitudes go to the unsigned core, signs are restored on writeback
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic                  div_start, div_done;
  logic [DATA_WIDTH-1:0] div_quo, div_rem;
  logic [DATA_WIDTH-1:0] quo_fix, rem_fix, div_hi, div_lo;
  logic                  quo_neg, rem_neg, div_by_zero;

  assign a_neg     = (op == OpDiv) && operand_a[DATA_WIDTH-1];
  assign b_neg     = (op == OpDiv) && operand_b[DATA_WIDTH-1];
  assign abs_a     = a_neg ? -operand_a : operand_a;
  assign abs_b     = b_neg ? -operand_b : operand_b;
  assign div_start = accept && is_div;

  muldiv_unit_div_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (flush),
    .dividend (abs_a),
    .divisor  (abs_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign quo_neg     = signed_q && (op_a_q[DATA_WIDTH-1] ^ op_b_q[DATA_WIDTH-1]);
  assign rem_neg     = signed_q && op_a_q[DATA_WIDTH-1];
  assign div_by_zero = (op_b_q == '0);
  assign quo_fix     = quo_neg ? -div_quo : div_quo;
  assign rem_fix     = rem_neg ? -div_rem : div_rem;
  assign div_lo      = div_by_zero ? '1 : quo_fix;
  assign div_hi      = div_by_zero ? op_a_q : rem_fix;

  always_comb begin
    stall_req = 1'b0;
    if (!flush) begin
      case (state_q)
        StIdle:       stall_req = valid_in && (is_mul || is_div);
        StMul, StDiv: stall_req = 1'b1;
        default:      stall_req = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_in) begin
            case (op)
              OpMult, OpMultu: begin
                state_d = StMul;
                cnt_d   = '0;
              end
              OpDiv, OpDivu: state_d = StDiv;
              OpMthi:        hi_d = operand_a;
              OpMtlo:        lo_d = operand_a;
              default:       ;
            endcase
          end
        end
        StMul: begin
          if (cnt_q == CntLast) begin
            {hi_d, lo_d} = mul_result;
            state_d      = StDone;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDiv: begin
          if (div_done) begin
            hi_d    = div_hi;
            lo_d    = div_lo;
            state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (accept && (is_mul || is_div)) begin
        op_a_q   <= operand_a;
        op_b_q   <= operand_b;
        signed_q <= (op == OpMult) || (op == OpDiv);
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
